// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes engine: substitutes LANES bytes of a 128-bit state
// per clock behind valid/ready handshakes on both sides.
module inv_sub_bytes_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned N  = 16 / LANES;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [127:0]    st, st_n;
  logic [3:0]      bidx;
  logic [6:0]      lsb;

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [10:0] pos;
    pos = 11'(8 * (255 - int'(y)));
    return INV_SBOX[pos +: 8];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      st    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      st    <= st_n;
    end
  end

  // Next-state, handshake and per-cycle lane substitution.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    st_n     = st;
    in_ready = 1'b0;
    bidx     = '0;
    lsb      = '0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && in_ready) begin
          st_n    = in_data;
          cnt_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < int'(LANES); l++) begin
          bidx = 4'(int'(cnt) * int'(LANES) + l);
          lsb  = 7'(8 * (15 - int'(bidx)));
          st_n[lsb +: 8] = inv_sbox(st[lsb +: 8]);
        end
        if (cnt == CW'(N - 1)) begin
          cnt_n   = '0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        // Result drain and next load share one edge when both sides are ready.
        in_ready = out_ready && !rst;
        if (out_ready) begin
          if (in_valid) begin
            st_n    = in_data;
            cnt_n   = '0;
            state_n = BUSY;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign out_data  = st;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter across LANES = 4, 1, 2, 8, 16.
module tb_inv_sub_bytes_iter;

  localparam int NI = 5;
  localparam int unsigned LANES_TBL [NI] = '{4, 1, 2, 8, 16};
  localparam logic [127:0] V1_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] V1_OUT = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V2_IN  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
  localparam logic [127:0] V2_OUT = 128'h101112131415161718191a1b1c1d1e1f;

  logic         clk;
  logic         rst;
  logic         iv    [NI];
  logic         ordy  [NI];
  logic [127:0] idata [NI];
  logic         irdy  [NI];
  logic         ov    [NI];
  logic         bsy   [NI];
  logic [127:0] odata [NI];

  int checks = 0;
  int errors = 0;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      inv_sub_bytes_iter #(.LANES(LANES_TBL[g])) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv[g]),
        .in_ready  (irdy[g]),
        .in_data   (idata[g]),
        .out_valid (ov[g]),
        .out_ready (ordy[g]),
        .out_data  (odata[g]),
        .busy      (bsy[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Forward S-box from first principles: GF inverse (x^254) then affine map.
  function automatic logic [7:0] sbox_model(input logic [7:0] v);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < 254; k++) r = gmul(r, v);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic consume(input int i);
    ordy[i] = 1'b1;
    tick();
    ordy[i] = 1'b0;
  endtask

  // Offer one block, wait for the accept, then count cycles until out_valid.
  task automatic send_wait(input int i, input logic [127:0] d, output int lat, output bit bok);
    int guard;
    guard = 0;
    iv[i] = 1'b1;
    idata[i] = d;
    #1;
    while (irdy[i] !== 1'b1 && guard < 50) begin
      tick();
      #1;
      guard++;
    end
    tick();
    iv[i] = 1'b0;
    lat = 0;
    bok = 1'b1;
    while (ov[i] !== 1'b1 && lat < 40) begin
      if (bsy[i] !== 1'b1) bok = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (ov[i] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", i, ov[i]); end
      checks++;
      if (irdy[i] !== 1'b0) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 0", i, irdy[i]); end
      checks++;
      if (bsy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", i, bsy[i]); end
      checks++;
      if (odata[i] !== 128'h0) begin errors++; $display("FAIL reset_out_data[%0d]: got %h expected 0", i, odata[i]); end
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (irdy[i] !== 1'b1) begin errors++; $display("FAIL release_in_ready[%0d]: got %b expected 1", i, irdy[i]); end
    end
  endtask

  task automatic test_vector1();
    int lat;
    bit bok;
    send_wait(0, V1_IN, lat, bok);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL v1_latency: got %0d expected 4", lat); end
    checks++;
    if (bok !== 1'b1) begin errors++; $display("FAIL v1_busy_during: got %b expected 1", bok); end
    checks++;
    if (odata[0] !== V1_OUT) begin errors++; $display("FAIL v1_data: got %h expected %h", odata[0], V1_OUT); end
    checks++;
    if (bsy[0] !== 1'b1) begin errors++; $display("FAIL v1_busy_done: got %b expected 1", bsy[0]); end
    consume(0);
    checks++;
    if (bsy[0] !== 1'b0 || ov[0] !== 1'b0) begin
      errors++; $display("FAIL v1_idle_after: got busy=%b valid=%b expected 0 0", bsy[0], ov[0]);
    end
  endtask

  task automatic test_vectors();
    int lat;
    bit bok;
    logic [127:0] din, exp_d;
    logic [127:0] vin  [2];
    logic [127:0] vout [2];
    vin[0] = V2_IN;          vout[0] = V2_OUT;
    vin[1] = {16{8'h63}};    vout[1] = 128'h0;
    for (int v = 0; v < 2; v++) begin
      send_wait(0, vin[v], lat, bok);
      checks++;
      if (odata[0] !== vout[v] || lat != 4) begin
        errors++; $display("FAIL vector%0d: got %h lat %0d expected %h lat 4", v, odata[0], lat, vout[v]);
      end
      consume(0);
    end
    // Every byte value, through the forward model and back.
    for (int b = 0; b < 16; b++) begin
      for (int j = 0; j < 16; j++) begin
        exp_d[127 - 8*j -: 8] = 8'(16 * b + j);
        din[127 - 8*j -: 8]   = sbox_model(8'(16 * b + j));
      end
      send_wait(0, din, lat, bok);
      checks++;
      if (odata[0] !== exp_d || lat != 4) begin
        errors++; $display("FAIL roundtrip%0d: got %h lat %0d expected %h lat 4", b, odata[0], lat, exp_d);
      end
      consume(0);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit bok;
    send_wait(0, V1_IN, lat, bok);
    checks++;
    if (ov[0] !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", ov[0]); end
    iv[0] = 1'b1;
    idata[0] = {16{8'hed}};
    ordy[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (ov[0] !== 1'b1 || odata[0] !== V1_OUT || irdy[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h ready=%b expected 1 %h 0", c, ov[0], odata[0], irdy[0], V1_OUT);
      end
      tick();
    end
    ordy[0] = 1'b1;
    #1;
    checks++;
    if (irdy[0] !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", irdy[0]); end
    tick();
    iv[0] = 1'b0;
    ordy[0] = 1'b0;
    checks++;
    if (bsy[0] !== 1'b1 || ov[0] !== 1'b0) begin
      errors++; $display("FAIL bp_reload: got busy=%b valid=%b expected 1 0", bsy[0], ov[0]);
    end
    lat = 0;
    while (ov[0] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (odata[0] !== {16{8'h53}} || lat != 4) begin
      errors++; $display("FAIL bp_next: got %h lat %0d expected %h lat 4", odata[0], lat, {16{8'h53}});
    end
    consume(0);
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    bit bok;
    iv[0] = 1'b1;
    idata[0] = V2_IN;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || bsy[0] !== 1'b0 || odata[0] !== 128'h0 || irdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort: got valid=%b busy=%b data=%h ready=%b expected 0 0 0 0", ov[0], bsy[0], odata[0], irdy[0]);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (irdy[0] !== 1'b1) begin errors++; $display("FAIL abort_release_ready: got %b expected 1", irdy[0]); end
    send_wait(0, {16{8'h16}}, lat, bok);
    checks++;
    if (odata[0] !== {16{8'hff}} || lat != 4) begin
      errors++; $display("FAIL abort_next: got %h lat %0d expected %h lat 4", odata[0], lat, {16{8'hff}});
    end
    consume(0);
  endtask

  task automatic test_lanes_sweep();
    int lat;
    bit bok;
    int exp_lat;
    for (int i = 1; i < NI; i++) begin
      exp_lat = int'(16 / LANES_TBL[i]);
      send_wait(i, V1_IN, lat, bok);
      checks++;
      if (lat != exp_lat) begin
        errors++; $display("FAIL sweep_latency L%0d: got %0d expected %0d", LANES_TBL[i], lat, exp_lat);
      end
      checks++;
      if (odata[i] !== V1_OUT || bok !== 1'b1) begin
        errors++; $display("FAIL sweep_data L%0d: got %h busy_ok %b expected %h 1", LANES_TBL[i], odata[i], bok, V1_OUT);
      end
      consume(i);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d [3];
    logic [127:0] e [3];
    int acc [3];
    int nacc, nout, n;
    bit take, otake;
    d[0] = V1_IN;  e[0] = V1_OUT;
    d[1] = V2_IN;  e[1] = V2_OUT;
    d[2] = {16{8'h63}}; e[2] = 128'h0;
    for (int i = 0; i < NI; i++) begin
      n = int'(16 / LANES_TBL[i]);
      nacc = 0;
      nout = 0;
      for (int k = 0; k < 3; k++) acc[k] = -1000 * (k + 1);
      iv[i] = 1'b1;
      idata[i] = d[0];
      ordy[i] = 1'b1;
      for (int cyc = 0; cyc < 120 && (nacc < 3 || nout < 3); cyc++) begin
        #1;
        take  = (irdy[i] === 1'b1) && iv[i];
        otake = (ov[i] === 1'b1) && ordy[i];
        if (otake) begin
          if (nout < 3) begin
            checks++;
            if (odata[i] !== e[nout]) begin
              errors++; $display("FAIL b2b_data L%0d #%0d: got %h expected %h", LANES_TBL[i], nout, odata[i], e[nout]);
            end
          end
          nout++;
        end
        tick();
        if (take && nacc < 3) begin
          acc[nacc] = cyc;
          nacc++;
          if (nacc < 3) idata[i] = d[nacc];
          else iv[i] = 1'b0;
        end
      end
      iv[i] = 1'b0;
      ordy[i] = 1'b0;
      checks++;
      if (nacc != 3 || nout != 3) begin
        errors++; $display("FAIL b2b_count L%0d: got acc=%0d out=%0d expected 3 3", LANES_TBL[i], nacc, nout);
      end
      checks++;
      if (acc[1] - acc[0] != n + 1 || acc[2] - acc[1] != n + 1) begin
        errors++;
        $display("FAIL b2b_spacing L%0d: got %0d %0d expected %0d", LANES_TBL[i], acc[1] - acc[0], acc[2] - acc[1], n + 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b0;
      idata[i] = '0;
    end
    tick();
    tick();
    test_reset();
    tick();
    test_vector1();
    test_vectors();
    test_backpressure();
    test_reset_mid_busy();
    test_lanes_sweep();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
